// File: rtl/vga_sync_timing.sv
// Vertical line counter and registered sync/blanking decode for a VGA raster.
// Consumes the upstream horizontal count and end-of-line strobe; all outputs are flops.
module vga_sync_timing #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic        clk_25MHz,
  input  logic        rst,
  input  logic [15:0] H_Count_Value,
  input  logic        enable_V_Counter,
  output logic [15:0] V_Count_Value,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start,
  output logic [7:0]  frame_count
);

  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_VIS_END    = 16'(H_ACTIVE);
  localparam logic [15:0] H_SYNC_START = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] H_SYNC_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] V_VIS_END    = 16'(V_ACTIVE);
  localparam logic [15:0] V_SYNC_START = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] V_SYNC_END   = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] V_LAST       = 16'(V_TOTAL - 1);

  logic [15:0] v_count_q, v_count_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        video_on_q, video_on_d;
  logic [9:0]  pixel_x_q, pixel_x_d;
  logic [9:0]  pixel_y_q, pixel_y_d;
  logic        frame_start_q, frame_start_d;
  logic [7:0]  frame_count_q, frame_count_d;

  logic wrap;
  logic h_sync_zone;
  logic v_sync_zone;
  logic visible;

  // enable_V_Counter is a plain level strobe with no backpressure: every cycle
  // it is high advances one line, and the decode always sees the pre-update line.
  always_comb begin
    wrap        = enable_V_Counter && (v_count_q == V_LAST);
    h_sync_zone = (H_Count_Value >= H_SYNC_START) && (H_Count_Value < H_SYNC_END);
    v_sync_zone = (v_count_q >= V_SYNC_START) && (v_count_q < V_SYNC_END);
    visible     = (H_Count_Value < H_VIS_END) && (v_count_q < V_VIS_END);

    v_count_d     = v_count_q;
    frame_count_d = frame_count_q;
    if (enable_V_Counter) begin
      v_count_d = wrap ? 16'd0 : v_count_q + 16'd1;
    end
    if (wrap) begin
      frame_count_d = frame_count_q + 8'd1;
    end

    frame_start_d = wrap;
    hsync_d       = h_sync_zone ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d       = v_sync_zone ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    video_on_d    = visible;
    pixel_x_d     = visible ? H_Count_Value[9:0] : 10'd0;
    pixel_y_d     = visible ? v_count_q[9:0] : 10'd0;
  end

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      v_count_q     <= 16'd0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      video_on_q    <= 1'b0;
      pixel_x_q     <= 10'd0;
      pixel_y_q     <= 10'd0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      v_count_q     <= v_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign V_Count_Value = v_count_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign video_on      = video_on_q;
  assign pixel_x       = pixel_x_q;
  assign pixel_y       = pixel_y_q;
  assign frame_start   = frame_start_q;
  assign frame_count   = frame_count_q;

endmodule

// File: doc/vga_sync_timing.md
# vga_sync_timing

Downstream stage of the horizontal pixel counter in the VGA controller. It consumes the horizontal count and the end-of-line strobe, and maintains the vertical line counter. It produces registered hsync, vsync, video_on, pixel coordinates and frame markers for the pixel generator and the VGA pins. Default parameters give 640x480 @ 60 Hz on the 25 MHz pixel clock.

## Interface

Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, in pixels
- H_SYNC, 96: hsync pulse width, in pixels
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch, in lines
- V_SYNC, 2: vsync pulse width, in lines
- V_BP, 33: vertical back porch, in lines
- SYNC_ACTIVE, 0: asserted level of hsync and vsync (0 = active-low)
- Derived: V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525

Ports:
- clk_25MHz  in  1  pixel clock; all logic runs on the rising edge
- rst  in  1  synchronous, active-high reset
- H_Count_Value  in  16  horizontal count from the upstream counter
- enable_V_Counter  in  1  one-cycle end-of-line strobe from the upstream counter
- V_Count_Value  out  16  current line number, 0..V_TOTAL-1
- hsync  out  1  horizontal sync at SYNC_ACTIVE level
- vsync  out  1  vertical sync at SYNC_ACTIVE level
- video_on  out  1  high while the current pixel is visible
- pixel_x  out  10  visible column; 0 when video_on=0
- pixel_y  out  10  visible row; 0 when video_on=0
- frame_start  out  1  one-cycle pulse on the first cycle of line 0
- frame_count  out  8  count of completed frames, wraps

## Operation

Reset values (one clock with rst=1):
- V_Count_Value=0, video_on=0, pixel_x=0, pixel_y=0, frame_start=0, frame_count=0
- hsync=vsync=~SYNC_ACTIVE (inactive)

Vertical counter:
- On enable_V_Counter=1: if V_Count_Value==V_TOTAL-1, wrap to 0; otherwise increment.
- Otherwise hold.

Frame markers:
- Wrap event = enable_V_Counter=1 while V_Count_Value==V_TOTAL-1.
- On a wrap event: frame_start=1 for exactly one cycle, and frame_count increments (255 wraps to 0).
- frame_start=0 at all other times.

Decode (registered). Each cycle, let h = H_Count_Value input and v = V_Count_Value before this cycle's update:
- hsync active iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751)
- vsync active iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491)
- video_on iff h < H_ACTIVE and v < V_ACTIVE
- pixel_x = h[9:0] and pixel_y = v[9:0] when visible; both 0 otherwise

Boundary rules:
- Any h >= H_ACTIVE+H_FP+H_SYNC, including values at or beyond 800, is blanking: hsync inactive, video_on=0. No error is raised.
- rst has priority over enable_V_Counter and over a wrap event: no frame_start pulse and no frame_count increment in the reset cycle.
- Reset mid-frame restarts at line 0. It does not wait for a frame boundary.
- enable_V_Counter held high for several cycles advances one line per cycle. No edge detection is performed.
- All comparisons are done at full 16-bit width. Truncation to 10 bits happens only on pixel_x and pixel_y.

## Timing

- Latency from H_Count_Value to hsync, video_on and pixel_x is exactly 1 cycle.
- V_Count_Value updates on the edge that samples enable_V_Counter=1, so the new line is visible 1 cycle after the strobe.
- The decode in the strobe cycle uses the old line number.
- frame_start goes high in the same cycle that V_Count_Value first reads 0. frame_count shows its new value in that same cycle.
- No combinational path from any input to any output.

## Test plan

- Reset: hold rst=1 with random inputs -> V_Count_Value=0, hsync=vsync=1, video_on=0, frame_start=0, frame_count=0.
- Horizontal decode at v=0:
  - h=639 -> video_on=1 and pixel_x=639, one cycle later.
  - h=640 -> video_on=0.
  - h=655 -> hsync=1; h=656 -> hsync=0; h=751 -> hsync=0; h=752 -> hsync=1.
  - h=800 -> hsync=1 and video_on=0.
- Line advance: 489 strobes from reset -> V_Count_Value=489, vsync=1. Strobe 490 -> vsync=0. Strobes 490 and 491 keep vsync=0. Strobe 492 -> vsync=1.
- Frame wrap: 525 strobes -> V_Count_Value=0, frame_start high for exactly one cycle, frame_count=1. Repeat 256 frames -> frame_count=0.
- Reset priority: at V_Count_Value=524, assert rst and enable_V_Counter together -> V_Count_Value=0, frame_start=0, frame_count=0.
- Closed loop with the upstream counter, full frame: hsync pulses of 96 cycles, video_on high for exactly 640x480 cycles per frame, vsync 2 lines wide.
